dmem_arbiter: RTL and testbench

Two-port burst arbiter and sequencer for the single-port 64-word data memory. Two requesters (r0: CPU load/store unit, r1: DMA/debug loader) issue word bursts of 1–4 beats. The block grants one requester at a time, generates incrementing word addresses with wrap-around, and drives the memory's write enable, address and write data. Read data is registered back to the owner. It sits between the requesters and the data memory, which has a synchronous write and a combinational read.

---
 rtl/dmem_arb_pkg.sv | 32 +++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory burst arbiter.
// Arbitration policy is selected with DMEM_ARB_RR_EN (see rr_arbiter2).
package dmem_arb_pkg;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned LEN_W       = 2;
   localparam int unsigned DEPTH_WORDS = 64;
   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);

   localparam logic R0 = 1'b0;
   localparam logic R1 = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   // Burst context captured at grant time.
   typedef struct packed {
      logic             owner;
      logic             we;
      logic [IDX_W-1:0] base;
      logic [LEN_W-1:0] len;
   } burst_t;

   // Word index to byte address; upper address bits are always zero.
   function automatic logic [ADDR_W-1:0] word_to_byte(input logic [IDX_W-1:0] idx);
      return ADDR_W'({idx, 2'b00});
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant decision. DMEM_ARB_RR_EN selects round-robin on ties;
// otherwise r0 has fixed priority and last_owner is ignored.
module rr_arbiter2
   import dmem_arb_pkg::*;
(
   input  logic r0_req,
   input  logic r1_req,
   input  logic last_owner,
   output logic gnt_valid_c,
   output logic gnt_owner_c
);

   always_comb begin
      gnt_valid_c = r0_req | r1_req;
      gnt_owner_c = R0;
`ifdef DMEM_ARB_RR_EN
      if (r0_req && r1_req) begin
         gnt_owner_c = (last_owner == R0) ? R1 : R0;
      end else if (r1_req) begin
         gnt_owner_c = R1;
      end
`else
      if (!r0_req && r1_req) begin
         gnt_owner_c = R1;
      end
`endif
   end

`ifndef DMEM_ARB_RR_EN
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port burst arbiter/sequencer for the 64-word data memory.
// Tie policy follows DMEM_ARB_RR_EN through rr_arbiter2.
module dmem_arbiter
   import dmem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [LEN_W-1:0]  r0_len,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_beat,
   output logic              r0_done,
   output logic              r0_rvalid,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [LEN_W-1:0]  r1_len,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_beat,
   output logic              r1_done,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   state_e            state_q, state_d;
   burst_t            burst_q, burst_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              last_owner_q, last_owner_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              r0_rvalid_q, r0_rvalid_d;
   logic              r1_rvalid_q, r1_rvalid_d;

   logic              arb_valid;
   logic              arb_owner;
   logic [IDX_W-1:0]  word_idx;
   logic              last_beat;

   // Only the word-index bits of the byte address are meaningful.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{r0_addr[ADDR_W-1:IDX_W+2], r0_addr[1:0],
                               r1_addr[ADDR_W-1:IDX_W+2], r1_addr[1:0]};

   rr_arbiter2 u_arb (
      .r0_req      (r0_req),
      .r1_req      (r1_req),
      .last_owner  (last_owner_q),
      .gnt_valid_c (arb_valid),
      .gnt_owner_c (arb_owner)
   );

   assign word_idx  = burst_q.base + IDX_W'(beat_cnt_q);
   assign last_beat = (beat_cnt_q == burst_q.len);

   // Next-state and memory-side decode.
   always_comb begin
      state_d      = state_q;
      burst_d      = burst_q;
      beat_cnt_d   = beat_cnt_q;
      last_owner_d = last_owner_q;
      rdata_d      = rdata_q;
      r0_rvalid_d  = 1'b0;
      r1_rvalid_d  = 1'b0;
      r0_gnt       = 1'b0;
      r1_gnt       = 1'b0;
      r0_beat      = 1'b0;
      r1_beat      = 1'b0;
      r0_done      = 1'b0;
      r1_done      = 1'b0;
      mem_we       = 1'b0;
      mem_a        = '0;
      mem_wd       = '0;

      case (state_q)
         IDLE: begin
            // Grants are suppressed while reset is asserted.
            if (arb_valid && !reset) begin
               burst_d.owner = arb_owner;
               burst_d.we    = (arb_owner == R1) ? r1_we : r0_we;
               burst_d.base  = (arb_owner == R1) ? r1_addr[IDX_W+1:2] : r0_addr[IDX_W+1:2];
               burst_d.len   = (arb_owner == R1) ? r1_len : r0_len;
               beat_cnt_d    = '0;
               last_owner_d  = arb_owner;
               r0_gnt        = (arb_owner == R0);
               r1_gnt        = (arb_owner == R1);
               state_d       = BURST;
            end
         end
         BURST: begin
            mem_we  = burst_q.we;
            mem_a   = word_to_byte(word_idx);
            mem_wd  = (burst_q.owner == R1) ? r1_wdata : r0_wdata;
            r0_beat = (burst_q.owner == R0);
            r1_beat = (burst_q.owner == R1);
            if (!burst_q.we) begin
               rdata_d     = mem_rd;
               r0_rvalid_d = (burst_q.owner == R0);
               r1_rvalid_d = (burst_q.owner == R1);
            end
            if (last_beat) begin
               r0_done = (burst_q.owner == R0) && !reset;
               r1_done = (burst_q.owner == R1) && !reset;
               state_d = IDLE;
            end else begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         burst_q      <= '0;
         beat_cnt_q   <= '0;
         last_owner_q <= R1;
         rdata_q      <= '0;
         r0_rvalid_q  <= 1'b0;
         r1_rvalid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         burst_q      <= burst_d;
         beat_cnt_q   <= beat_cnt_d;
         last_owner_q <= last_owner_d;
         rdata_q      <= rdata_d;
         r0_rvalid_q  <= r0_rvalid_d;
         r1_rvalid_q  <= r1_rvalid_d;
      end
   end

   assign rdata     = rdata_q;
   assign r0_rvalid = r0_rvalid_q;
   assign r1_rvalid = r1_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants,
// beats and read returns; a negedge monitor compares against the DUT.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
   logic [1:0]  r0_len, r1_len;
   logic        r0_gnt, r0_beat, r0_done, r0_rvalid;
   logic        r1_gnt, r1_beat, r1_done, r1_rvalid;
   logic [31:0] rdata, mem_a, mem_wd, mem_rd;
   logic        mem_we;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_len(r0_len), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_beat(r0_beat), .r0_done(r0_done), .r0_rvalid(r0_rvalid),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_len(r1_len), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_beat(r1_beat), .r1_done(r1_done), .r1_rvalid(r1_rvalid),
      .rdata(rdata), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // Physical memory: synchronous write, combinational read.
   logic [31:0] mem [64];
   assign mem_rd = mem[mem_a[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

   typedef struct packed {
      logic            valid;
      logic            we;
      logic [31:0]     addr;
      logic [1:0]      len;
      logic [3:0][31:0] data;
   } req_t;

   typedef struct packed { int cyc; logic owner; } gnt_e;
   typedef struct packed {
      int cyc; logic owner; logic we; logic [31:0] a; logic [31:0] wd; logic done;
   } beat_e;
   typedef struct packed { int cyc; logic owner; logic [31:0] d; } rd_e;

   req_t  pend [2];
   gnt_e  gnt_q [$];
   beat_e beat_q [$];
   rd_e   rd_q [$];

   // Reference model state.
   logic [31:0]      ref_mem [64];
   bit               active;
   logic             a_owner, a_we;
   int               a_base, a_len, a_k;
   logic [3:0][31:0] a_data;
   logic             mdl_last_owner;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
   endtask

   function automatic logic [3:0][31:0] mk(input logic [31:0] a, b, c, d);
      logic [3:0][31:0] r;
      r[0] = a; r[1] = b; r[2] = c; r[3] = d;
      return r;
   endfunction

   function automatic logic choose();
`ifdef DMEM_ARB_RR_EN
      if (pend[0].valid && pend[1].valid) return (mdl_last_owner == 1'b0) ? 1'b1 : 1'b0;
`else
      if (pend[0].valid && pend[1].valid) return 1'b0;
`endif
      return pend[1].valid ? 1'b1 : 1'b0;
   endfunction

   // One cycle of the reference: a burst occupies len+1 beat cycles after its grant.
   task automatic model_step();
      int  idx;
      logic own;
      if (active) begin
         idx = (a_base + a_k) % 64;
         beat_q.push_back('{cyc, a_owner, a_we, 32'(idx * 4), a_data[a_k],
                            (a_k == a_len) && !reset});
         if (a_we) ref_mem[idx] = a_data[a_k];
         else if (!reset) rd_q.push_back('{cyc + 1, a_owner, ref_mem[idx]});
         if (reset || a_k == a_len) active = 1'b0;
         else a_k++;
      end else if (!reset && (pend[0].valid || pend[1].valid)) begin
         own = choose();
         gnt_q.push_back('{cyc, own});
         active         = 1'b1;
         a_owner        = own;
         a_we           = pend[own].we;
         a_base         = int'(pend[own].addr[7:2]);
         a_len          = int'(pend[own].len);
         a_k            = 0;
         a_data         = pend[own].data;
         mdl_last_owner = own;
         pend[own].valid = 1'b0;
      end
      if (reset) begin
         active         = 1'b0;
         mdl_last_owner = 1'b1;
      end
   endtask

   task automatic cycle();
      r0_req = pend[0].valid; r0_we = pend[0].we; r0_addr = pend[0].addr; r0_len = pend[0].len;
      r1_req = pend[1].valid; r1_we = pend[1].we; r1_addr = pend[1].addr; r1_len = pend[1].len;
      r0_wdata = $urandom;
      r1_wdata = $urandom;
      if (active) begin
         if (a_owner) r1_wdata = a_data[a_k];
         else         r0_wdata = a_data[a_k];
      end
      model_step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input int n, input logic we, input logic [31:0] addr,
                        input logic [1:0] len, input logic [3:0][31:0] d);
      pend[n] = '{1'b1, we, addr, len, d};
   endtask

   task automatic drain();
      int k = 0;
      while ((pend[0].valid || pend[1].valid || active) && k < 300) begin
         cycle();
         k++;
      end
      if (k >= 300) begin
         n_chk++;
         $display("FAIL drain_timeout cyc=%0d actual=busy required=idle", cyc);
      end
      cycle();
      cycle();
   endtask

   function automatic logic [3:0][31:0] rnd4();
      return mk($urandom, $urandom, $urandom, $urandom);
   endfunction

   // Monitor: compare every cycle against the head of each expected stream.
   always @(negedge clk) begin
      if (mon_en) begin
         if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
            check("gnt", 64'({r1_gnt, r0_gnt}), gnt_q[0].owner ? 64'd2 : 64'd1);
            void'(gnt_q.pop_front());
         end else begin
            check("gnt_idle", 64'({r1_gnt, r0_gnt}), 64'd0);
         end
         if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
            check("beat", 64'({r1_beat, r0_beat}), beat_q[0].owner ? 64'd2 : 64'd1);
            check("mem_we", 64'(mem_we), 64'(beat_q[0].we));
            check("mem_a", 64'(mem_a), 64'(beat_q[0].a));
            check("mem_wd", 64'(mem_wd), 64'(beat_q[0].wd));
            check("done", 64'({r1_done, r0_done}),
                  beat_q[0].done ? (beat_q[0].owner ? 64'd2 : 64'd1) : 64'd0);
            void'(beat_q.pop_front());
         end else begin
            check("idle_bus", 64'({r1_beat, r0_beat, r1_done, r0_done, mem_we}), 64'd0);
            check("idle_addr", {mem_a, mem_wd}, 64'd0);
         end
         if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            check("rvalid", 64'({r1_rvalid, r0_rvalid}), rd_q[0].owner ? 64'd2 : 64'd1);
            check("rdata", 64'(rdata), 64'(rd_q[0].d));
            void'(rd_q.pop_front());
         end else begin
            check("rvalid_idle", 64'({r1_rvalid, r0_rvalid}), 64'd0);
         end
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]     = 32'hA500_0000 + 32'(i);
         ref_mem[i] = 32'hA500_0000 + 32'(i);
      end
      pend[0] = '0; pend[1] = '0;
      active = 1'b0; a_owner = 1'b0; a_we = 1'b0; a_base = 0; a_len = 0; a_k = 0;
      a_data = '0; mdl_last_owner = 1'b1;
      reset = 1'b1;
      r0_req = 0; r0_we = 0; r0_addr = 0; r0_len = 0; r0_wdata = 0;
      r1_req = 0; r1_we = 0; r1_addr = 0; r1_len = 0; r1_wdata = 0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      cycle();
      check("reset_rdata", 64'(rdata), 64'd0);
      reset = 1'b0;
      cycle();

      // Single write then single read.
      issue(0, 1'b1, 32'h10, 2'd0, mk(32'hDEAD_BEEF, 0, 0, 0));
      drain();
      issue(0, 1'b0, 32'h10, 2'd0, '0);
      drain();

      // Four-beat write and read-back from r1.
      issue(1, 1'b1, 32'h20, 2'd3, mk(1, 2, 3, 4));
      drain();
      issue(1, 1'b0, 32'h20, 2'd3, rnd4());
      drain();

      // Wrap-around burst.
      issue(0, 1'b1, 32'hF8, 2'd3, rnd4());
      drain();
      issue(1, 1'b0, 32'hF8, 2'd3, rnd4());
      drain();

      // Ignored address bits.
      issue(0, 1'b0, 32'hFFFF_FF13, 2'd0, '0);
      drain();

      // Continuous contention, single-beat reads.
      for (int i = 0; i < 16; i++) begin
         if (!pend[0].valid) issue(0, 1'b0, 32'($urandom_range(0, 255)), 2'd0, rnd4());
         if (!pend[1].valid) issue(1, 1'b0, 32'($urandom_range(0, 255)), 2'd0, rnd4());
         cycle();
      end
      drain();

      // Reset during the second beat of a four-beat write.
      issue(0, 1'b1, 32'h80, 2'd3, mk(32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003));
      for (int k = 0; k < 20 && !(active && a_k == 1); k++) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
      issue(1, 1'b0, 32'h80, 2'd3, rnd4());
      drain();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!pend[n].valid && $urandom_range(0, 3) == 0)
               issue(n, 1'($urandom), $urandom, 2'($urandom), rnd4());
         end
         cycle();
      end
      drain();

      mon_en = 1'b0;
      check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
      check("beat_q_empty", 64'(beat_q.size()), 64'd0);
      check("rd_q_empty", 64'(rd_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
